// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-fetch responder.
// Holds the NOP word, default widths and the pipeline stage record.
package imem_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int DEPTH_W_DEF = 6;

    // addi x0, x0, 0 -- returned in place of data on a bad fetch
    localparam logic [DATA_W_DEF-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [DATA_W_DEF-1:0] data;
    } stage_t;

endpackage

// File: rtl/sync_fifo.sv
// Ordered single-clock FIFO holding fetch responses.
// DEPTH must be a power of two; pointers carry one wrap bit.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    assign empty = (r_wr == r_rd);
    assign full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);

    assign pop_data = r_mem[r_rd[AW-1:0]];

    // Pointer update; wrap is modulo DEPTH through the low bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + (AW+1)'(1);
            if (w_do_pop)  r_rd <= r_rd + (AW+1)'(1);
        end
    end

    // Entry storage, not reset: only slots behind r_wr are ever read
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: word store, error check, fixed
// latency pipeline, credit counter and ordered response FIFO.
module imem_fetch_responder
    import imem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH_W    = DEPTH_W_DEF,
    parameter int LAT        = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_data,
    output logic               rsp_err,
    input  logic               wr_en,
    input  logic [DEPTH_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]  wr_data
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0]  r_mem [2**DEPTH_W];
    logic [CNT_W-1:0]   r_count;
    logic               w_accept;
    logic               w_rsp_hs;
    logic               w_misalign;
    logic               w_range;
    logic [DEPTH_W-1:0] w_idx;
    logic               w_empty;
    logic               w_full;
    logic [DATA_W:0]    w_head;
    stage_t             w_s0;
    stage_t             w_last;

    // Ready comes only from the registered credit count
    assign req_ready = !rst && (r_count < CNT_W'(FIFO_DEPTH));
    assign w_accept  = req_valid && req_ready;
    assign w_rsp_hs  = rsp_valid && rsp_ready;

    assign w_idx      = req_addr[DEPTH_W+1:2];
    assign w_misalign = |req_addr[1:0];
    assign w_range    = |req_addr[ADDR_W-1:DEPTH_W+2];

    // Accept-cycle stage: store read is combinational, so a same
    // cycle write to this word is seen only after the edge
    always_comb begin
        w_s0.valid = w_accept;
        w_s0.err   = w_misalign || w_range;
        w_s0.data  = r_mem[w_idx];
        if (w_misalign || w_range) w_s0.data = NOP_INSTR;
    end

    // Preload write port; the store survives reset
    always_ff @(posedge clk) begin
        if (wr_en) r_mem[wr_addr] <= wr_data;
    end

    // Credits cover everything in flight plus everything queued
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            unique case ({w_accept, w_rsp_hs})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // The accept cycle is the first of LAT stages; the other
    // LAT-1 are registers that always advance
    generate
        if (LAT == 1) begin : g_nopipe
            assign w_last = w_s0;
        end else begin : g_pipe
            stage_t r_pipe [LAT-1];

            // Shift the stage records; reset drops in-flight work
            always_ff @(posedge clk) begin
                r_pipe[0] <= w_s0;
                for (int i = 1; i < LAT - 1; i++) begin
                    r_pipe[i] <= r_pipe[i-1];
                end
                if (rst) begin
                    for (int i = 0; i < LAT - 1; i++) begin
                        r_pipe[i].valid <= 1'b0;
                    end
                end
            end

            assign w_last = r_pipe[LAT-2];
        end
    endgenerate

    sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_last.valid && !w_full),
        .push_data ({w_last.err, w_last.data}),
        .pop       (w_rsp_hs),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign rsp_valid = !w_empty;
    assign rsp_err   = w_empty ? 1'b0 : w_head[DATA_W];
    assign rsp_data  = w_empty ? '0 : w_head[DATA_W-1:0];

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Self-checking bench for imem_fetch_responder (LAT=2, depth 4).
// Scoreboard queue plus per-scenario inline checks.
module tb_imem_fetch_responder;

    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;

    int total = 0;
    int bad   = 0;

    logic [32:0] sbq [$];
    logic [31:0] m_mem [64];

    imem_fetch_responder #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .DEPTH_W    (6),
        .LAT        (2),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] expect_of(logic [31:0] a);
        if (a[1:0] != 2'b00 || a[31:8] != 24'h0)
            return {1'b1, 32'h0000_0013};
        return {1'b0, m_mem[a[7:2]]};
    endfunction

    // Scoreboard monitor: sampled mid-cycle, read modelled before write
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst) begin
            sbq.delete();
        end else begin
            total++;
            if (req_ready !== (sbq.size() < FD)) begin
                bad++;
                $display("FAIL credit: req_ready=%b outstanding=%0d",
                         req_ready, sbq.size());
            end
            if (rsp_valid === 1'b0) begin
                total++;
                if ({rsp_err, rsp_data} !== 33'h0) begin
                    bad++;
                    $display("FAIL idle_out: got %h want 0",
                             {rsp_err, rsp_data});
                end
            end
            if (rsp_valid && rsp_ready) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL stale: got %h with nothing owed",
                             {rsp_err, rsp_data});
                end else begin
                    e = sbq.pop_front();
                    if ({rsp_err, rsp_data} !== e) begin
                        bad++;
                        $display("FAIL order: got %h want %h",
                                 {rsp_err, rsp_data}, e);
                    end
                end
            end
            if (req_valid && req_ready)
                sbq.push_back(expect_of(req_addr));
        end
        if (wr_en) m_mem[wr_addr] = wr_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int idx, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = 6'(idx);
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic await_rsp(output logic got);
        got = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic drain();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 40 && sbq.size() != 0; i++) tick();
        tick();
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain: outstanding=%0d want 0", sbq.size());
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        rsp_ready = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        tick();
        tick();
        @(negedge clk);
        total += 4;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_ready: got %b want 0", req_ready);
        end
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_valid: got %b want 0", rsp_valid);
        end
        if (rsp_data !== 32'h0) begin
            bad++;
            $display("FAIL rst_data: got %h want 0", rsp_data);
        end
        if (rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL rst_err: got %b want 0", rsp_err);
        end
        tick();
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_release: req_ready=%b want 1", req_ready);
        end
        tick();
    endtask

    task automatic preload();
        for (int i = 0; i < 64; i++)
            write_word(i, 32'hA500_0000 ^ (32'(i) * 32'h0001_0203));
        write_word(0, 32'h0010_0093);
        write_word(1, 32'h0020_0113);
        write_word(2, 32'h0030_8193);
        write_word(3, 32'h0040_8213);
        write_word(5, 32'h1111_1111);
    endtask

    task automatic test_in_order();
        logic [31:0] w [4];
        w[0] = 32'h0010_0093;
        w[1] = 32'h0020_0113;
        w[2] = 32'h0030_8193;
        w[3] = 32'h0040_8213;
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req_valid = (k < 4);
            req_addr  = 32'(k) * 4;
            @(negedge clk);
            if (k < 4) begin
                total++;
                if (req_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_accept[%0d]: ready=%b want 1",
                             k, req_ready);
                end
            end
            total++;
            if (rsp_valid !== (k >= 2 && k <= 5)) begin
                bad++;
                $display("FAIL b2b_valid[%0d]: got %b want %b",
                         k, rsp_valid, (k >= 2 && k <= 5));
            end
            if (k >= 2 && k <= 5) begin
                total++;
                if (rsp_data !== w[k-2] || rsp_err !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_data[%0d]: got %h/%b want %h/0",
                             k, rsp_data, rsp_err, w[k-2]);
                end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_errors();
        logic [31:0] a [3];
        logic [32:0] x [3];
        logic        got;
        a[0] = 32'h0000_0006;
        a[1] = 32'h0000_0100;
        a[2] = 32'h0000_00FC;
        x[0] = {1'b1, 32'h0000_0013};
        x[1] = {1'b1, 32'h0000_0013};
        x[2] = {1'b0, m_mem[63]};
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_addr  = a[i];
            tick();
            req_valid = 1'b0;
            await_rsp(got);
            total++;
            if (!got) begin
                bad++;
                $display("FAIL err_timeout[%0d]: no response", i);
            end else if ({rsp_err, rsp_data} !== x[i]) begin
                bad++;
                $display("FAIL err_rsp[%0d]: got %h want %h",
                         i, {rsp_err, rsp_data}, x[i]);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_backpressure();
        int acc;
        acc       = 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'(i) * 4;
            @(negedge clk);
            if (req_ready) acc++;
            tick();
        end
        total++;
        if (acc != FD) begin
            bad++;
            $display("FAIL bp_accepts: got %0d want %0d", acc, FD);
        end
        @(negedge clk);
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_full: req_ready=%b want 0", req_ready);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_no_bypass: req_ready=%b want 0", req_ready);
        end
        tick();
        rsp_ready = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: req_ready=%b want 1", req_ready);
        end
        tick();
        drain();
    endtask

    task automatic test_collision();
        logic got;
        rsp_ready = 1'b1;
        wr_en     = 1'b1;
        wr_addr   = 6'd5;
        wr_data   = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        req_addr  = 32'h14;
        tick();
        wr_en     = 1'b0;
        req_valid = 1'b0;
        await_rsp(got);
        total++;
        if (!got || rsp_data !== 32'h1111_1111) begin
            bad++;
            $display("FAIL rbw_old: got %h valid=%b want 11111111",
                     rsp_data, got);
        end
        tick();
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        await_rsp(got);
        total++;
        if (!got || rsp_data !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL rbw_new: got %h valid=%b want deadbeef",
                     rsp_data, got);
        end
        tick();
        drain();
    endtask

    task automatic test_reset_inflight();
        logic got;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'(i) * 4;
            tick();
        end
        rst      = 1'b1;
        req_addr = 32'hC;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL rstf_ready: got %b want 0", req_ready);
        end
        tick();
        rst       = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL rstf_release: got %b want 1", req_ready);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL rstf_stale[%0d]: rsp_valid=%b want 0",
                         i, rsp_valid);
            end
            tick();
        end
        req_valid = 1'b1;
        req_addr  = 32'h0;
        tick();
        req_valid = 1'b0;
        await_rsp(got);
        total++;
        if (!got || rsp_data !== 32'h0010_0093) begin
            bad++;
            $display("FAIL rstf_store: got %h valid=%b want 00100093",
                     rsp_data, got);
        end
        tick();
        drain();
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 2000; c++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            r = $urandom_range(0, 9);
            if (r == 0)
                req_addr = {$urandom_range(0, 63), 2'b00} + 32'h2;
            else if (r == 1)
                req_addr = 32'h100 + {$urandom_range(0, 255), 2'b00};
            else
                req_addr = 32'($urandom_range(0, 63)) << 2;
            wr_en   = ($urandom_range(0, 15) == 0);
            wr_addr = 6'($urandom_range(0, 63));
            wr_data = $urandom;
            tick();
        end
        wr_en = 1'b0;
        drain();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        preload();
        test_in_order();
        test_errors();
        test_backpressure();
        test_collision();
        test_reset_inflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
